// File: rtl/rv_imm_pkg.sv
// Immediate-source coding shared with the core, plus the signed range check
// used when packing an immediate back into an instruction word.
package rv_imm_pkg;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam int IMM_W_IS = 12;
   localparam int IMM_W_B  = 13;
   localparam int IMM_W_J  = 21;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } packed_ent_t;

   // True when imm is a sign extension of its low 'width' bits.
   function automatic logic imm_fits(input logic [31:0] imm, input int width);
      logic [31:0] upper;
      upper = $signed(imm) >>> (width - 1);
      return (upper == '0) || (upper == '1);
   endfunction

endpackage

// File: rtl/imm_pack_comb.sv
// Scatters a 32-bit immediate into the bit fields of an I/S/B/J instruction
// and flags immediates the chosen format cannot hold.
module imm_pack_comb
   import rv_imm_pkg::*;
(
   input  logic [31:0] in_base,
   input  logic [31:0] in_imm,
   input  logic [1:0]  in_immsrc,
   output logic [31:0] instr,
   output logic        err
);

   always_comb begin
      instr = in_base;
      err   = 1'b0;
      case (in_immsrc)
         IMM_I: begin
            instr[31:20] = in_imm[11:0];
            err          = !imm_fits(in_imm, IMM_W_IS);
         end
         IMM_S: begin
            instr[31:25] = in_imm[11:5];
            instr[11:7]  = in_imm[4:0];
            err          = !imm_fits(in_imm, IMM_W_IS);
         end
         IMM_B: begin
            instr[31]    = in_imm[12];
            instr[30:25] = in_imm[10:5];
            instr[11:8]  = in_imm[4:1];
            instr[7]     = in_imm[11];
            err          = !imm_fits(in_imm, IMM_W_B) || in_imm[0];
         end
         default: begin
            instr[31]    = in_imm[20];
            instr[30:21] = in_imm[10:1];
            instr[20]    = in_imm[11];
            instr[19:12] = in_imm[19:12];
            err          = !imm_fits(in_imm, IMM_W_J) || in_imm[0];
         end
      endcase
   end

endmodule

// File: rtl/imm_packer.sv
// Valid/ready immediate packer: packs at push time into a small output FIFO
// and keeps saturating counts of accepted and unrepresentable requests.
module imm_packer
   import rv_imm_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_base,
   input  logic [31:0]      in_imm,
   input  logic [1:0]       in_immsrc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]   count_reg, count_next;
   logic [CNT_W-1:0] enc_count_reg, err_count_reg;
   logic             push, pop;
   logic [31:0]      pack_instr;
   logic             pack_err;
   packed_ent_t      ent_q [DEPTH];
   packed_ent_t      head;

   imm_pack_comb u_pack (
      .in_base   (in_base),
      .in_imm    (in_imm),
      .in_immsrc (in_immsrc),
      .instr     (pack_instr),
      .err       (pack_err)
   );

   assign in_ready  = (count_reg != FULL_CNT);
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Entry storage is deliberately unreset; the head is masked while empty.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
         packed_ent_t ent_reg;
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi)))
               ent_reg <= '{instr: pack_instr, err: pack_err};
         end
         assign ent_q[gi] = ent_reg;
      end
   endgenerate

   assign head      = ent_q[rd_ptr_reg];
   assign out_instr = out_valid ? head.instr : '0;
   assign out_err   = out_valid ? head.err : 1'b0;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg     <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         enc_count_reg <= '0;
         err_count_reg <= '0;
      end else begin
         count_reg <= count_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (enc_count_reg != '1)
               enc_count_reg <= enc_count_reg + 1'b1;
            if (pack_err && (err_count_reg != '1))
               err_count_reg <= err_count_reg + 1'b1;
         end
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   assign enc_count = enc_count_reg;
   assign err_count = err_count_reg;

endmodule

// File: tb/tb_imm_packer.sv
// Randomized bench for imm_packer: queue-based reference model, per-cycle
// compare process, directed literal cases and a round-trip decode check.
module tb_imm_packer;

   localparam int DEPTH   = 2;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_base;
   logic [31:0]      in_imm;
   logic [1:0]       in_immsrc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic             out_err;
   logic [CNT_W-1:0] enc_count;
   logic [CNT_W-1:0] err_count;

   imm_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_base   (in_base),
      .in_imm    (in_imm),
      .in_immsrc (in_immsrc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] imm;
      logic [1:0]  src;
      logic [31:0] instr;
      logic        err;
   } ent_t;

   ent_t q[$];
   int   m_enc = 0;
   int   m_err = 0;
   int   n_acc = 0;
   bit   acc = 0;
   bit   chk_en = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference packing: whole-word concatenation per format, range by signed bounds.
   function automatic ent_t model_pack(input logic [31:0] b, input logic [31:0] i, input logic [1:0] s);
      ent_t e;
      longint v;
      v = longint'($signed(i));
      e.imm = i;
      e.src = s;
      case (s)
         2'd0: begin
            e.instr = {i[11:0], b[19:0]};
            e.err   = (v < -2048) || (v > 2047);
         end
         2'd1: begin
            e.instr = {i[11:5], b[24:12], i[4:0], b[6:0]};
            e.err   = (v < -2048) || (v > 2047);
         end
         2'd2: begin
            e.instr = {i[12], i[10:5], b[24:12], i[4:1], i[11], b[6:0]};
            e.err   = (v < -4096) || (v > 4095) || (v % 2 != 0);
         end
         default: begin
            e.instr = {i[20], i[10:1], i[11], i[19:12], b[11:0]};
            e.err   = (v < -1048576) || (v > 1048575) || (v % 2 != 0);
         end
      endcase
      return e;
   endfunction

   // Core-style immediate extension, used for the round-trip invariant.
   function automatic logic [31:0] extend(input logic [31:0] x, input logic [1:0] s);
      case (s)
         2'd0:    return {{20{x[31]}}, x[31:20]};
         2'd1:    return {{20{x[31]}}, x[31:25], x[11:7]};
         2'd2:    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
         default: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      endcase
   endfunction

   always @(posedge clk) begin
      bit do_push, do_pop;
      ent_t e;
      if (rst) begin
         q.delete();
         m_enc = 0;
         m_err = 0;
         acc = 0;
      end else begin
         do_pop  = (q.size() != 0) && out_ready;
         do_push = in_valid && (q.size() < DEPTH);
         acc = do_push;
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e = model_pack(in_base, in_imm, in_immsrc);
            q.push_back(e);
            n_acc++;
            if (m_enc < CNT_MAX) m_enc++;
            if (e.err && m_err < CNT_MAX) m_err++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("out_instr", out_instr, (q.size() != 0) ? q[0].instr : 32'h0);
         chk("out_err", 32'(out_err), (q.size() != 0) ? 32'(q[0].err) : 32'h0);
         chk("enc_count", 32'(enc_count), 32'(m_enc));
         chk("err_count", 32'(err_count), 32'(m_err));
         if (q.size() != 0 && !q[0].err)
            chk("round_trip", extend(out_instr, q[0].src), q[0].imm);
      end
   end

   // Presents one request at a negedge and holds it until accepted.
   task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [1:0] s);
      int n;
      n = 0;
      in_base = b; in_imm = i; in_immsrc = s; in_valid = 1'b1;
      @(posedge clk); #1;
      while (!acc && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         errors++;
         $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic rand_req();
      int w;
      logic [31:0] r;
      w = $urandom_range(1, 24);
      r = $urandom;
      in_base   = $urandom;
      in_immsrc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) in_imm = $urandom;
      else in_imm = 32'($signed(r << (32 - w)) >>> (32 - w));
      if ($urandom_range(0, 1) == 1) in_imm[0] = 1'b0;
   endtask

   initial begin
      ent_t p;
      int   cyc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_base = '0; in_imm = '0; in_immsrc = '0;

      p = model_pack(32'h00000013, 32'hFFFFFFFB, 2'd0);
      chk("model_I", p.instr, 32'hFFB00013);
      p = model_pack(32'h00000063, 32'hFFFFFFFC, 2'd2);
      chk("model_B", p.instr, 32'hFE000EE3);
      p = model_pack(32'h0000006F, 32'h00100000, 2'd3);
      chk("model_J_err", 32'(p.err), 32'h1);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_enc", 32'(enc_count), 32'h0);

      send(32'h00000013, 32'hFFFFFFFB, 2'd0);
      chk("I_instr", out_instr, 32'hFFB00013);
      chk("I_err", 32'(out_err), 32'h0);
      chk("I_enc", 32'(enc_count), 32'h1);
      send(32'h00002023, 32'h00000008, 2'd1);
      chk("S_instr", out_instr, 32'h00002423);
      send(32'h00000063, 32'hFFFFFFFC, 2'd2);
      chk("B_instr", out_instr, 32'hFE000EE3);
      send(32'h0000006F, 32'h00000800, 2'd3);
      chk("J_instr", out_instr, 32'h0010006F);
      send(32'h00000013, 32'h00000800, 2'd0);
      chk("Ierr_field", 32'(out_instr[31:20]), 32'h800);
      chk("Ierr_err", 32'(out_err), 32'h1);
      chk("Ierr_cnt", 32'(err_count), 32'h1);
      send(32'h00000063, 32'h00000003, 2'd2);
      chk("Berr_err", 32'(out_err), 32'h1);
      send(32'h0000006F, 32'h00100000, 2'd3);
      chk("Jerr_err", 32'(out_err), 32'h1);
      chk("err_cnt3", 32'(err_count), 32'h3);

      // Backpressure: two accepted, third held while the FIFO is full.
      @(negedge clk);
      out_ready = 1'b0;
      send(32'h00000013, 32'h00000001, 2'd0);
      send(32'h00000013, 32'h00000002, 2'd0);
      in_base = 32'h00000013; in_imm = 32'h3; in_immsrc = 2'd0; in_valid = 1'b1;
      chk("bp_full", 32'(in_ready), 32'h0);
      repeat (3) @(negedge clk);
      chk("bp_held_ready", 32'(in_ready), 32'h0);
      chk("bp_head", out_instr, 32'h00100013);
      chk("bp_enc", 32'(enc_count), 32'h9);
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (acc) rand_req();
         @(negedge clk);
      end

      // Random sweep until 10k more requests have been accepted.
      cyc = 0;
      n_acc = 0;
      while (n_acc < 10000 && cyc < 40000) begin
         if (!in_valid || acc) begin
            rand_req();
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         cyc++;
      end
      chk("sweep_done", 32'(n_acc >= 10000), 32'h1);

      // Reset while full with a request pending: nothing survives or is counted.
      out_ready = 1'b0;
      rand_req();
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      chk("pre_rst_full", 32'(in_ready), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_ready", 32'(in_ready), 32'h1);
      chk("mid_rst_enc", 32'(enc_count), 32'h0);
      chk("mid_rst_err", 32'(err_count), 32'h0);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
